// File: rtl/rmii_rx_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rmii_rx_pkg
// Shared types and constants for the RMII receive frame controller:
//   - rx_state_e  : frame controller states (IDLE, PRE, DATA, DROP)
//   - DIBIT_PRE   : preamble dibit 2'b01
//   - DIBIT_SFD   : start-of-frame-delimiter dibit 2'b11
//   - CRC_POLY / CRC_INIT / CRC_RESIDUE : reflected CRC-32 constants used
//     when the design is built with RMII_RX_CRC_CHECK_EN defined.
// ---------------------------------------------------------------------------
package rmii_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_e;

  localparam logic [1:0] DIBIT_PRE = 2'b01;
  localparam logic [1:0] DIBIT_SFD = 2'b11;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Register value left behind after running the CRC over a frame
  // including its own (correct) FCS.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/rmii_rx_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// rmii_rx_frame_ctrl_if
// Bundles the dibit input stream and the frame byte output stream of
// rmii_rx_frame_ctrl.
//   i_rmii_rxvld / i_rmii_rxdata : dibit stream from the CDC FIFO
//   o_frame_vld / o_frame_data   : one byte per o_frame_vld pulse
//   o_frame_sof / o_frame_eof    : first / last byte markers
//   o_frame_err                  : frame bad, meaningful with o_frame_eof
//   o_frame_cnt / o_err_cnt      : saturating good / errored frame counts
// Modports:
//   master : the frame controller (consumes dibits, sources frame bytes)
//   slave  : the surrounding logic (sources dibits, consumes frame bytes)
// ---------------------------------------------------------------------------
interface rmii_rx_frame_ctrl_if;

  logic        i_rmii_rxvld;
  logic [1:0]  i_rmii_rxdata;
  logic        o_frame_vld;
  logic [7:0]  o_frame_data;
  logic        o_frame_sof;
  logic        o_frame_eof;
  logic        o_frame_err;
  logic [15:0] o_frame_cnt;
  logic [15:0] o_err_cnt;

  modport master (
    input  i_rmii_rxvld, i_rmii_rxdata,
    output o_frame_vld, o_frame_data, o_frame_sof, o_frame_eof,
           o_frame_err, o_frame_cnt, o_err_cnt
  );

  modport slave (
    output i_rmii_rxvld, i_rmii_rxdata,
    input  o_frame_vld, o_frame_data, o_frame_sof, o_frame_eof,
           o_frame_err, o_frame_cnt, o_err_cnt
  );

endinterface

// File: rtl/rmii_rx_frame_ctrl_crc32_d8.sv
// ---------------------------------------------------------------------------
// crc32_d8
// Combinational one-byte update of the reflected CRC-32
// (polynomial 32'hEDB88320). Data bits are consumed LSB first, matching the
// on-wire bit order of Ethernet.
//   i_crc  : current CRC register
//   i_data : byte to fold in
//   o_crc  : updated CRC register
// Only compiled when RMII_RX_CRC_CHECK_EN is defined; without the macro no
// CRC logic exists in the build.
// ---------------------------------------------------------------------------
`ifdef RMII_RX_CRC_CHECK_EN
module crc32_d8
  import rmii_rx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  function automatic logic [31:0] crc_step8(input logic [31:0] c,
                                            input logic [7:0]  d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  assign o_crc = crc_step8(i_crc, i_data);

endmodule
`endif

// File: rtl/rmii_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// rmii_rx_frame_ctrl
// Receive-side frame controller: hunts preamble + SFD in the dibit stream,
// assembles LSB-first bytes, delimits frames by an idle timeout and emits a
// byte stream with sof/eof/err flags plus saturating good/error counters.
//
// Ports:
//   i_clk   : system clock (only clock)
//   i_rst_n : asynchronous active-low reset
//   rx_if   : rmii_rx_frame_ctrl_if.master (dibits in, frame bytes out)
// Parameters:
//   P_MIN_PRE : minimum preamble dibits before SFD is accepted
//   P_IDLE_TO : idle cycles that close a frame
//   P_MIN_LEN : runt threshold in bytes (FCS included)
//   P_MAX_LEN : oversize threshold in bytes
// Build option:
//   RMII_RX_CRC_CHECK_EN : when defined, a CRC-32 residue check also flags
//                          the frame as errored.
// ---------------------------------------------------------------------------
module rmii_rx_frame_ctrl
  import rmii_rx_pkg::*;
#(
  parameter int P_MIN_PRE = 8,
  parameter int P_IDLE_TO = 8,
  parameter int P_MIN_LEN = 64,
  parameter int P_MAX_LEN = 1518
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rmii_rx_frame_ctrl_if.master rx_if
);

  localparam int IW = $clog2(P_IDLE_TO + 1);

  rx_state_e   state, state_nxt;
  logic [7:0]  pre_cnt;
  logic [IW-1:0] idle_cnt;
  logic [7:0]  shift_p0;
  logic [1:0]  phase;
  logic [7:0]  held_p0;
  logic [15:0] byte_cnt;

  logic        vld;
  logic [1:0]  dib;
  logic [7:0]  shift_nxt;
  logic        timeout, byte_done, oversize;
  logic        emit_mid, emit_ovs, emit_to;
  logic        crc_bad, frame_bad;
  logic        out_vld_d, out_sof_d, out_eof_d, out_err_d;

  logic        frame_vld_p1, frame_sof_p1, frame_eof_p1, frame_err_p1;
  logic [7:0]  frame_data_p1;
  logic [15:0] frame_cnt, err_cnt;

  assign vld       = rx_if.i_rmii_rxvld;
  assign dib       = rx_if.i_rmii_rxdata;
  assign shift_nxt = {dib, shift_p0[7:2]};
  // A coinciding vld always wins over the timeout.
  assign timeout   = !vld && (idle_cnt == IW'(P_IDLE_TO - 1));
  assign byte_done = (state == ST_DATA) && vld && (phase == 2'd3);
  assign oversize  = byte_done && (byte_cnt == 16'(P_MAX_LEN));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (vld && dib == DIBIT_PRE) state_nxt = ST_PRE;
      ST_PRE: begin
        if (vld) begin
          if (dib == DIBIT_PRE)
            state_nxt = ST_PRE;
          else if (dib == DIBIT_SFD && pre_cnt >= 8'(P_MIN_PRE))
            state_nxt = ST_DATA;
          else
            state_nxt = ST_IDLE;
        end else if (timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (oversize)     state_nxt = ST_DROP;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_DROP: if (timeout) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: output decode. The held byte goes out when the next byte completes,
  // when the frame times out (as the last byte), or as a forced eof when an
  // oversize byte completes.
  always_comb begin
    emit_mid  = byte_done && (byte_cnt != 16'd0) && !oversize;
    emit_ovs  = oversize;
    emit_to   = (state == ST_DATA) && timeout && (byte_cnt != 16'd0);
    frame_bad = (phase != 2'd0) || (byte_cnt < 16'(P_MIN_LEN)) || crc_bad;
    out_vld_d = emit_mid || emit_ovs || emit_to;
    out_sof_d = out_vld_d && (byte_cnt == 16'd1);
    out_eof_d = emit_ovs || emit_to;
    out_err_d = emit_ovs || (emit_to && frame_bad);
  end

  // -------------------------------------------------------------------------
  // Stage p0: preamble/idle counting and byte assembly
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_cnt  <= 8'd0;
      idle_cnt <= '0;
      shift_p0 <= 8'd0;
      phase    <= 2'd0;
      held_p0  <= 8'd0;
      byte_cnt <= 16'd0;
    end else begin
      if (vld || state_nxt != state)
        idle_cnt <= '0;
      else if (idle_cnt != IW'(P_IDLE_TO))
        idle_cnt <= idle_cnt + IW'(1);

      if (state == ST_IDLE && vld && dib == DIBIT_PRE)
        pre_cnt <= 8'd1;
      else if (state == ST_PRE && vld && dib == DIBIT_PRE && pre_cnt != 8'hFF)
        pre_cnt <= pre_cnt + 8'd1;

      if (state == ST_PRE && state_nxt == ST_DATA) begin
        shift_p0 <= 8'd0;
        phase    <= 2'd0;
        byte_cnt <= 16'd0;
      end else if (state == ST_DATA && vld) begin
        shift_p0 <= shift_nxt;
        phase    <= phase + 2'd1;
        if (byte_done) begin
          held_p0 <= shift_nxt;
          if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
        end
      end
    end
  end

`ifdef RMII_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_upd;

  crc32_d8 u_crc (
    .i_crc  (crc_q),
    .i_data (shift_nxt),
    .o_crc  (crc_upd)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                 crc_q <= CRC_INIT;
    else if (state == ST_PRE && state_nxt == ST_DATA) crc_q <= CRC_INIT;
    else if (byte_done)                           crc_q <= crc_upd;
  end

  assign crc_bad = (crc_q != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Stage p1: registered frame outputs and counters
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_vld_p1  <= 1'b0;
      frame_sof_p1  <= 1'b0;
      frame_eof_p1  <= 1'b0;
      frame_err_p1  <= 1'b0;
      frame_data_p1 <= 8'h00;
      frame_cnt     <= 16'd0;
      err_cnt       <= 16'd0;
    end else begin
      frame_vld_p1 <= out_vld_d;
      frame_sof_p1 <= out_sof_d;
      frame_eof_p1 <= out_eof_d;
      frame_err_p1 <= out_err_d;
      if (out_vld_d) frame_data_p1 <= held_p0;
      if (out_eof_d && !out_err_d && frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;
      if (out_eof_d && out_err_d && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

  assign rx_if.o_frame_vld  = frame_vld_p1;
  assign rx_if.o_frame_data = frame_data_p1;
  assign rx_if.o_frame_sof  = frame_sof_p1;
  assign rx_if.o_frame_eof  = frame_eof_p1;
  assign rx_if.o_frame_err  = frame_err_p1;
  assign rx_if.o_frame_cnt  = frame_cnt;
  assign rx_if.o_err_cnt    = err_cnt;

endmodule

// File: tb/tb_rmii_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rmii_rx_frame_ctrl
// Drives dibit bursts (preamble, SFD, frame bytes, optional trailing dibits)
// into rmii_rx_frame_ctrl. A frame-level model predicts every output byte,
// its flags and the clock edge it must appear on; one compare process checks
// the DUT on every output byte. Counters are checked after each burst.
// ---------------------------------------------------------------------------
module tb_rmii_rx_frame_ctrl;

  localparam int P_MIN_PRE = 8;
  localparam int P_IDLE_TO = 8;
  localparam int P_MIN_LEN = 64;
  localparam int P_MAX_LEN = 1518;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       err;
    bit         tmo;
    int         trig;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  rmii_rx_frame_ctrl_if rx_if ();

  rmii_rx_frame_ctrl #(
    .P_MIN_PRE (P_MIN_PRE),
    .P_IDLE_TO (P_IDLE_TO),
    .P_MIN_LEN (P_MIN_LEN),
    .P_MAX_LEN (P_MAX_LEN)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .rx_if   (rx_if)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         mod_fcnt = 0;
  int         mod_ecnt = 0;
  bit         crc_en;
  logic [1:0] burst[$];
  logic [7:0] fbytes[$];
  logic [7:0] cbuf[$];
  int         dib_cyc[$];
  exp_t       exp_q[$];
  exp_t       ce;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Standard Ethernet FCS of cbuf[0..len-1] (final value already inverted).
  function automatic logic [31:0] crc_of(input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      c = c ^ {24'h0, cbuf[i]};
      for (int j = 0; j < 8; j++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic rand_bytes(input int n);
    fbytes.delete();
    repeat (n) fbytes.push_back(8'($urandom));
  endtask

  task automatic add_fcs();
    logic [31:0] f;
    cbuf = fbytes;
    f = crc_of(cbuf.size());
    for (int k = 0; k < 4; k++) fbytes.push_back(f[8*k +: 8]);
  endtask

  task automatic build(input int pre_len, input logic [1:0] sfd, input int extra);
    burst.delete();
    repeat (pre_len) burst.push_back(2'b01);
    burst.push_back(sfd);
    foreach (fbytes[k])
      for (int j = 0; j < 4; j++) burst.push_back(fbytes[k][2*j +: 2]);
    repeat (extra) burst.push_back(2'($urandom));
  endtask

  // Frame-level prediction for one burst that starts from idle and ends in
  // a gap longer than the idle timeout.
  task automatic model_burst(output int g, output int b);
    int   n, i, ds, run, nd, nb, rem;
    bit   crc_ok, ferr, last;
    exp_t e;
    g = 0; b = 0;
    n = burst.size(); i = 0; ds = -1;
    while (i < n && ds < 0) begin
      if (burst[i] == 2'b01) begin
        run = 0;
        while (i < n && burst[i] == 2'b01) begin run++; i++; end
        if (i < n) begin
          if (burst[i] == 2'b11 && run >= P_MIN_PRE) ds = i + 1;
          i++;
        end
      end else begin
        i++;
      end
    end
    if (ds < 0) return;
    nd = n - ds; nb = nd / 4; rem = nd % 4;
    cbuf.delete();
    for (int k = 0; k < nb; k++)
      cbuf.push_back({burst[ds+4*k+3], burst[ds+4*k+2], burst[ds+4*k+1], burst[ds+4*k]});
    if (nb == 0) return;
    if (nb > P_MAX_LEN) begin
      for (int k = 0; k < P_MAX_LEN; k++) begin
        e.d = cbuf[k]; e.sof = (k == 0); e.eof = (k == P_MAX_LEN - 1);
        e.err = e.eof; e.tmo = 0; e.trig = ds + 4*(k+1) + 3;
        exp_q.push_back(e);
      end
      b = 1;
    end else begin
      crc_ok = 1;
      if (crc_en)
        crc_ok = (nb >= 4) &&
                 (crc_of(nb - 4) == {cbuf[nb-1], cbuf[nb-2], cbuf[nb-3], cbuf[nb-4]});
      ferr = (rem != 0) || (nb < P_MIN_LEN) || !crc_ok;
      for (int k = 0; k < nb; k++) begin
        last = (k == nb - 1);
        e.d = cbuf[k]; e.sof = (k == 0); e.eof = last; e.err = last && ferr;
        e.tmo = last; e.trig = last ? (n - 1) : (ds + 4*(k+1) + 3);
        exp_q.push_back(e);
      end
      if (ferr) b = 1; else g = 1;
    end
  endtask

  // gap < 0: random 0..3 idle cycles before each dibit; otherwise fixed.
  task automatic drive_burst(input int gap, input int stop_at);
    int gl;
    dib_cyc.delete();
    for (int k = 0; k < burst.size() && k < stop_at; k++) begin
      gl = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (gl) begin
        rx_if.i_rmii_rxvld  = 1'b0;
        rx_if.i_rmii_rxdata = 2'($urandom);
        @(posedge clk); #1;
      end
      rx_if.i_rmii_rxvld  = 1'b1;
      rx_if.i_rmii_rxdata = burst[k];
      dib_cyc.push_back(cyc + 1);
      @(posedge clk); #1;
    end
    rx_if.i_rmii_rxvld = 1'b0;
  endtask

  task automatic run_burst(input int gap);
    int g, b;
    model_burst(g, b);
    drive_burst(gap, burst.size());
    repeat (P_IDLE_TO + 4) @(posedge clk);
    #1;
    check("queue_drain", exp_q.size(), 0);
    exp_q.delete();
    mod_fcnt += g;
    mod_ecnt += b;
    check("frame_cnt", rx_if.o_frame_cnt, mod_fcnt);
    check("err_cnt", rx_if.o_err_cnt, mod_ecnt);
  endtask

  // Compare process: every output byte against the model queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_if.o_frame_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", 1, 0);
      end else begin
        ce = exp_q.pop_front();
        check("byte_data", rx_if.o_frame_data, ce.d);
        check("byte_flags", {rx_if.o_frame_sof, rx_if.o_frame_eof, rx_if.o_frame_err},
              {ce.sof, ce.eof, ce.err});
        if (ce.trig < dib_cyc.size())
          check("byte_time", cyc, ce.tmo ? dib_cyc[ce.trig] + P_IDLE_TO : dib_cyc[ce.trig]);
        else
          check("byte_time", cyc, -1);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, b, nb, pre, ex;
    logic [1:0] sfd;
`ifdef RMII_RX_CRC_CHECK_EN
    crc_en = 1;
`else
    crc_en = 0;
`endif
    rst_n = 1'b0;
    rx_if.i_rmii_rxvld  = 1'b0;
    rx_if.i_rmii_rxdata = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", rx_if.o_frame_vld, 0);
    check("rst_sof", rx_if.o_frame_sof, 0);
    check("rst_eof", rx_if.o_frame_eof, 0);
    check("rst_err", rx_if.o_frame_err, 0);
    check("rst_data", rx_if.o_frame_data, 8'h00);
    check("rst_fcnt", rx_if.o_frame_cnt, 0);
    check("rst_ecnt", rx_if.o_err_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Model pin: CRC-32 check value of "123456789".
    cbuf.delete();
    for (int k = 0; k < 9; k++) cbuf.push_back(8'h31 + 8'(k));
    check("crc_pin", crc_of(9), 32'hCBF43926);

    // Good 64-byte frame, dibit every second cycle.
    rand_bytes(60); add_fcs();
    build(15, 2'b11, 0);
    run_burst(1);
    check("t1_fcnt_lit", rx_if.o_frame_cnt, 1);
    check("t1_ecnt_lit", rx_if.o_err_cnt, 0);

    // Same frame with a payload bit flipped.
    fbytes[20] = fbytes[20] ^ 8'h04;
    build(15, 2'b11, 0);
    run_burst(1);
    check("t2_ecnt_lit", rx_if.o_err_cnt, crc_en ? 1 : 0);
    check("t2_fcnt_lit", rx_if.o_frame_cnt, crc_en ? 1 : 2);

    // Preamble too short: nothing at all.
    fbytes.delete();
    repeat (64) fbytes.push_back(8'h00);
    build(4, 2'b11, 0);
    run_burst(-1);
    check("t3_fcnt_lit", rx_if.o_frame_cnt, crc_en ? 1 : 2);
    check("t3_ecnt_lit", rx_if.o_err_cnt, crc_en ? 1 : 0);

    // Oversize 1519-byte frame, then a normal frame.
    rand_bytes(1519);
    build(15, 2'b11, 0);
    run_burst(-1);
    check("t4_ecnt_lit", rx_if.o_err_cnt, crc_en ? 2 : 1);
    rand_bytes(76); add_fcs();
    build(10, 2'b11, 0);
    run_burst(-1);
    check("t4_fcnt_lit", rx_if.o_frame_cnt, crc_en ? 2 : 3);

    // Alignment error: two trailing dibits.
    rand_bytes(60); add_fcs();
    build(12, 2'b11, 2);
    run_burst(-1);
    check("t5_ecnt_lit", rx_if.o_err_cnt, crc_en ? 3 : 2);

    // Reset in the middle of a frame.
    rand_bytes(60); add_fcs();
    build(15, 2'b11, 0);
    model_burst(g, b);
    drive_burst(1, 16 + 100);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", rx_if.o_frame_vld, 0);
    check("mid_rst_eof", rx_if.o_frame_eof, 0);
    check("mid_rst_fcnt", rx_if.o_frame_cnt, 0);
    check("mid_rst_ecnt", rx_if.o_err_cnt, 0);
    exp_q.delete();
    mod_fcnt = 0;
    mod_ecnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rand_bytes(64); add_fcs();
    build(9, 2'b11, 0);
    run_burst(-1);
    check("t6_fcnt_lit", rx_if.o_frame_cnt, 1);
    check("t6_ecnt_lit", rx_if.o_err_cnt, 0);

    // Randomized bursts.
    for (int r = 0; r < 25; r++) begin
      nb = $urandom_range(1, 90);
      rand_bytes(nb);
      if ($urandom_range(0, 9) < 7) add_fcs();
      pre = $urandom_range(0, 14);
      sfd = ($urandom_range(0, 9) < 9) ? 2'b11 : 2'($urandom);
      ex  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      build(pre, sfd, ex);
      run_burst(-1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
